// File: rtl/pc_gen.sv
// Program counter generator with sticky halt, fetch-wait hold and a
// circular return-address stack for JR $ra prediction.
module pc_gen #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               INSTR_BYTES = 4,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ihit,
  input  logic                         halt,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         br_taken,
  input  logic [15:0]                  imm16,
  input  logic                         jump,
  input  logic [WIDTH-1:0]             jump_target,
  input  logic                         jal,
  input  logic                         jr_ret,
  input  logic [WIDTH-1:0]             jr_addr,
  output logic [WIDTH-1:0]             imemaddr,
  output logic                         imemREN,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              uf_q, uf_d;
  logic [WIDTH-1:0]  ras_q [RAS_DEPTH];

  logic              run;
  logic              adv;
  logic              push;
  logic [PW-1:0]     wr_idx;
  logic [WIDTH-1:0]  seq;
  logic [WIDTH-1:0]  boff;
  logic [WIDTH-1:0]  top;

  assign run  = (state_q == RUN);
  assign adv  = run & ihit & ~stall & ~halt;
  assign seq  = pc_q + WIDTH'(INSTR_BYTES);
  // sign-extend first, then scale words to bytes
  assign boff = {{(WIDTH-16){imm16[15]}}, imm16} << 2;
  assign top  = ras_q[ptr_q - PW'(1)];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    uf_d    = 1'b0;
    push    = 1'b0;
    wr_idx  = ptr_q;
    if (run && halt && ihit) state_d = HALTED;
    // pop before push so a combined jal+jr_ret reuses the popped slot
    if (adv && jr_ret) begin
      if (cnt_q != '0) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        uf_d = 1'b1;
      end
    end
    if (adv && jal) begin
      push   = 1'b1;
      wr_idx = ptr_d;
      ptr_d  = ptr_d + PW'(1);
      if (cnt_d != CW'(RAS_DEPTH)) cnt_d = cnt_d + CW'(1);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (run && redirect)   pc_d = redirect_pc;
    else if (!adv)         pc_d = pc_q;
    else if (jr_ret)       pc_d = (cnt_q != '0) ? top : jr_addr;
    else if (jump)         pc_d = jump_target;
    else if (br_taken)     pc_d = seq + boff;
    else                   pc_d = seq;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (push) begin
      ras_q[wr_idx] <= seq;
    end
  end

  assign imemaddr      = pc_q;
  assign imemREN       = run;
  assign halted        = ~run;
  assign ras_count     = cnt_q;
  assign ras_underflow = uf_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the single-cycle/pipelined datapath; drives the instruction memory address.
- Selects the next PC from four sources: sequential, branch (PC+4+imm), jump target, and register return. Redirect has highest priority among sources.
- Adds a sticky halt state, fetch-wait handling, and a return-address stack (RAS) that predicts the return target.
- Sits between control/hazard logic and the icache request interface.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  fetch of current imemaddr completed this cycle
- halt  in  1  halt instruction decoded
- stall  in  1  hazard stall; hold PC
- redirect  in  1  mispredict/flush from later stage; load redirect_pc
- redirect_pc  in  WIDTH  corrected PC
- br_taken  in  1  conditional branch taken
- imm16  in  16  branch word offset, signed
- jump  in  1  J/JAL; load jump_target
- jump_target  in  WIDTH  absolute jump address
- jal  in  1  push PC+INSTR_BYTES onto RAS (accompanies jump)
- jr_ret  in  1  JR $ra; pop RAS for target
- jr_addr  in  WIDTH  register value, fallback target
- imemaddr  out  WIDTH  current PC
- imemREN  out  1  fetch request
- halted  out  1  in HALTED state
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_underflow  out  1  one-cycle pulse: pop on empty RAS

Behaviour:
- Reset (async, nRST=0): PC=RESET_PC, state RUN, ras_count=0, RAS pointer=0, ras_underflow=0, halted=0, imemREN=1 once released. Reset mid-operation aborts everything immediately.
- States: RUN, HALTED.
  - RUN→HALTED when halt=1 and ihit=1.
  - HALTED exits only through reset. redirect is ignored while HALTED.
- In HALTED: PC frozen, imemREN=0, halted=1. No RAS changes.
- advance = RUN & ihit & ~stall & ~halt. redirect overrides stall and ihit: it loads in RUN regardless of them.
- Next-PC priority, registered at the rising edge:
  1. redirect → redirect_pc
  2. no advance → hold
  3. jr_ret → RAS top if ras_count>0, else jr_addr
  4. jump → jump_target
  5. br_taken → PC + INSTR_BYTES + (signext(imm16) << 2)
  6. otherwise → PC + INSTR_BYTES
- Arithmetic is modulo 2^WIDTH. The sign extension is applied before the shift.
- RAS updates only on advance, never on redirect:
  - Pop (jr_ret, count>0): decrement the pointer and count.
  - Pop (jr_ret, count=0): ras_underflow=1 for one cycle; the jr_addr target is used.
  - Push (jal): write PC+INSTR_BYTES at the pointer and increment the pointer circularly. count saturates at RAS_DEPTH; on overflow the oldest entry is overwritten silently.
  - jal & jr_ret in the same cycle: the pop is evaluated first (it supplies the target), then the push. Net count is unchanged when count>0.
- Combinational outputs: imemaddr = PC register. imemREN = (state==RUN).
- Latency: the new PC is visible on imemaddr one cycle after the qualifying edge.

Test Plan:
- Reset, then ihit=1 for 3 cycles → imemaddr 0x0, 0x4, 0x8, 0xC. With ihit=0 for 2 cycles → PC held at 0xC.
- Branch: at PC=0x100, br_taken=1, imm16=0xFFFE, advance → next PC 0x0FC. With imm16=0x0003 → 0x110.
- Priority: redirect=1 (redirect_pc=0x400) with stall=1, jump=1, ihit=0 → PC=0x400. With stall=1 only → PC held.
- RAS: jal+jump at PC=0x20 (target 0x200), then jr_ret with jr_addr=0xDEAD → PC=0x24, ras_count back to 0. A second jr_ret → PC=0xDEAD and a one-cycle ras_underflow pulse.
- RAS overflow: RAS_DEPTH=4, five jal pushes from PCs 0x0, 0x10, 0x20, 0x30, 0x40 → ras_count=4. Four pops return 0x44, 0x34, 0x24, 0x14.
- Halt: halt=1 with ihit=1 at PC=0x80 → halted=1, imemREN=0, PC stays 0x80 under redirect, branch and ihit. nRST pulse mid-halt → PC=RESET_PC, state RUN.
